// File: rtl/led_pwm_pkg.sv
// Shared constants and register layout for the LED PWM controller.
package led_pwm_pkg;

  localparam logic [1:0] MODE_STATIC  = 2'b00;
  localparam logic [1:0] MODE_BLINK   = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;
  localparam logic [1:0] MODE_PULSE   = 2'b11;

  localparam int unsigned OFF_CTRL   = 0;
  localparam int unsigned OFF_PRESC  = 1;
  localparam int unsigned OFF_STATUS = 2;
  localparam int unsigned OFF_CH0    = 3;

  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_RESTART_BIT = 1;

  localparam int unsigned CH_DUTY_LSB = 0;
  localparam int unsigned CH_RATE_LSB = 8;
  localparam int unsigned CH_MODE_LSB = 12;
  localparam int unsigned CH_EN_BIT   = 14;
  localparam int unsigned CH_CFG_W    = 15;
  localparam int unsigned PRESC_W     = 16;

  // Channel register image; field order matches the CHi bit positions above.
  typedef struct packed {
    logic       en;
    logic [1:0] mode;
    logic [3:0] rate;
    logic [7:0] duty;
  } ch_cfg_t;

  // Last phase value of a pulse: (rate+1)*16 ticks means phase 0..rate*16+15.
  function automatic logic [7:0] pulse_last(input logic [3:0] rate);
    return {rate, 4'hF};
  endfunction

endpackage

// File: rtl/led_pwm_chan.sv
// One LED channel: blink/breathe/pulse sequencing and the PWM compare.
module led_pwm_chan
  import led_pwm_pkg::*;
(
  input  logic       clk_sys_i,
  input  logic       rst_n_i,
  input  logic       tick,
  input  logic [7:0] pwm_cnt,
  input  ch_cfg_t    cfg,
  input  logic       cfg_wr,
  input  logic       restart,
  input  logic       en,
  output logic       led_on,
  output logic       pulse_done
);

  logic [7:0] phase_q;
  logic [7:0] ramp_q;
  logic       blink_on_q;
  logic       ramp_up_q;

  logic       clr;
  logic       rate_hit;
  logic       pulse_hit;
  logic [7:0] duty_eff;
  logic [7:0] ramp_nxt;
  logic       ramp_up_nxt;

  assign clr        = ~en | restart | cfg_wr;
  assign rate_hit   = (phase_q == {4'h0, cfg.rate});
  assign pulse_hit  = (phase_q == pulse_last(cfg.rate));
  assign pulse_done = ~clr & tick & cfg.en & (cfg.mode == MODE_PULSE) & pulse_hit;
  assign led_on     = en & cfg.en & (pwm_cnt < duty_eff);

  always_comb begin
    duty_eff = cfg.duty;
    unique case (cfg.mode)
      MODE_BLINK:   duty_eff = blink_on_q ? cfg.duty : 8'd0;
      MODE_BREATHE: duty_eff = ramp_q;
      default:      duty_eff = cfg.duty;
    endcase
  end

  // Triangle ramp: the top value is held for one step, then the ramp turns around.
  always_comb begin
    ramp_nxt    = ramp_q;
    ramp_up_nxt = ramp_up_q;
    if (ramp_up_q) begin
      if (ramp_q < cfg.duty) begin
        ramp_nxt = ramp_q + 8'd1;
      end else if (ramp_q != 8'd0) begin
        ramp_nxt    = ramp_q - 8'd1;
        ramp_up_nxt = 1'b0;
      end
    end else begin
      if (ramp_q != 8'd0) begin
        ramp_nxt = ramp_q - 8'd1;
      end else if (cfg.duty != 8'd0) begin
        ramp_nxt    = 8'd1;
        ramp_up_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      phase_q    <= '0;
      ramp_q     <= '0;
      blink_on_q <= 1'b1;
      ramp_up_q  <= 1'b1;
    end else if (clr) begin
      phase_q    <= '0;
      ramp_q     <= '0;
      blink_on_q <= 1'b1;
      ramp_up_q  <= 1'b1;
    end else if (tick) begin
      unique case (cfg.mode)
        MODE_BLINK: begin
          if (rate_hit) begin
            phase_q    <= '0;
            blink_on_q <= ~blink_on_q;
          end else begin
            phase_q <= phase_q + 8'd1;
          end
        end
        MODE_BREATHE: begin
          if (rate_hit) begin
            phase_q   <= '0;
            ramp_q    <= ramp_nxt;
            ramp_up_q <= ramp_up_nxt;
          end else begin
            phase_q <= phase_q + 8'd1;
          end
        end
        MODE_PULSE: begin
          if (!pulse_hit) phase_q <= phase_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped LED PWM controller: registers, time base and per-channel PWM.
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int unsigned MM_ADDR_WIDTH  = 8,
  parameter int unsigned MM_DATA_WIDTH  = 16,
  parameter int unsigned NUM_LEDS       = 8,
  parameter int unsigned REG_ADDR_BASE  = 'h10,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_n_i,
  input  logic [MM_ADDR_WIDTH-1:0] mm_s_addr_i,
  input  logic [MM_DATA_WIDTH-1:0] mm_s_wdata_i,
  output logic [MM_DATA_WIDTH-1:0] mm_s_rdata_o,
  input  logic                     mm_s_we_i,
  output logic [NUM_LEDS-1:0]      led_o
);

  localparam int unsigned NUM_REGS = OFF_CH0 + NUM_LEDS;
  localparam logic [MM_ADDR_WIDTH-1:0] BASE_A = MM_ADDR_WIDTH'(REG_ADDR_BASE);
  localparam logic [MM_ADDR_WIDTH-1:0] NREG_A = MM_ADDR_WIDTH'(NUM_REGS);
  localparam logic [NUM_LEDS-1:0]      LED_OFF = {NUM_LEDS{LED_ACTIVE_LOW}};

  logic                     ctrl_en_q;
  logic [PRESC_W-1:0]       presc_q;
  ch_cfg_t                  ch_q [NUM_LEDS];
  logic [NUM_LEDS-1:0]      led_state_q;
  logic [PRESC_W-1:0]       tick_cnt_q;
  logic [7:0]               pwm_cnt_q;

  logic [MM_ADDR_WIDTH-1:0] offset;
  logic                     in_win;
  logic                     reg_we;
  logic                     wr_ctrl;
  logic                     wr_presc;
  logic                     restart;
  logic                     tick;
  logic [NUM_LEDS-1:0]      ch_wr;
  logic [NUM_LEDS-1:0]      led_on;
  logic [NUM_LEDS-1:0]      pulse_done;
  logic [MM_DATA_WIDTH-1:0] rdata_c;

  assign offset   = mm_s_addr_i - BASE_A;
  assign in_win   = (mm_s_addr_i >= BASE_A) && (offset < NREG_A);
  assign reg_we   = mm_s_we_i & in_win;
  assign wr_ctrl  = reg_we & (offset == MM_ADDR_WIDTH'(OFF_CTRL));
  assign wr_presc = reg_we & (offset == MM_ADDR_WIDTH'(OFF_PRESC));
  assign restart  = wr_ctrl & mm_s_wdata_i[CTRL_RESTART_BIT];
  assign tick     = ctrl_en_q & (tick_cnt_q >= presc_q);

  // Readback; STATUS and unmapped addresses have no write path.
  always_comb begin
    rdata_c = '0;
    if (in_win) begin
      if (offset == MM_ADDR_WIDTH'(OFF_CTRL)) begin
        rdata_c = MM_DATA_WIDTH'(ctrl_en_q);
      end else if (offset == MM_ADDR_WIDTH'(OFF_PRESC)) begin
        rdata_c = MM_DATA_WIDTH'(presc_q);
      end else if (offset == MM_ADDR_WIDTH'(OFF_STATUS)) begin
        rdata_c = MM_DATA_WIDTH'(led_state_q);
      end else begin
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
          if (offset == MM_ADDR_WIDTH'(OFF_CH0 + i)) rdata_c = MM_DATA_WIDTH'(ch_q[i]);
        end
      end
    end
  end

  assign mm_s_rdata_o = rdata_c;

  // Register file; a bus write to CHi beats that channel's pulse completion.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_en_q <= 1'b0;
      presc_q   <= '0;
      for (int unsigned i = 0; i < NUM_LEDS; i++) ch_q[i] <= '0;
    end else begin
      if (wr_ctrl)  ctrl_en_q <= mm_s_wdata_i[CTRL_EN_BIT];
      if (wr_presc) presc_q   <= mm_s_wdata_i[PRESC_W-1:0];
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        if (ch_wr[i]) begin
          ch_q[i] <= ch_cfg_t'(mm_s_wdata_i[CH_CFG_W-1:0]);
        end else if (pulse_done[i]) begin
          ch_q[i].en <= 1'b0;
        end
      end
    end
  end

  // Shared time base, held at zero while globally disabled.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tick_cnt_q <= '0;
      pwm_cnt_q  <= '0;
    end else if (!ctrl_en_q || restart) begin
      tick_cnt_q <= '0;
      pwm_cnt_q  <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + PRESC_W'(1);
      pwm_cnt_q  <= pwm_cnt_q + 8'd1;
    end
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
    assign ch_wr[g] = reg_we & (offset == MM_ADDR_WIDTH'(OFF_CH0 + g));

    led_pwm_chan u_chan (
      .clk_sys_i  (clk_sys_i),
      .rst_n_i    (rst_n_i),
      .tick       (tick),
      .pwm_cnt    (pwm_cnt_q),
      .cfg        (ch_q[g]),
      .cfg_wr     (ch_wr[g]),
      .restart    (restart),
      .en         (ctrl_en_q),
      .led_on     (led_on[g]),
      .pulse_done (pulse_done[g])
    );
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      led_state_q <= '0;
      led_o       <= LED_OFF;
    end else begin
      led_state_q <= led_on;
      led_o       <= led_on ^ LED_OFF;
    end
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Bench for led_pwm_ctrl: directed scenarios plus random traffic against a tick-count model.
module tb_led_pwm_ctrl;

  localparam int NL = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [15:0] wdata = 16'h0000;
  logic        we = 1'b0;
  logic [15:0] rdata;
  logic [7:0]  led;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_on = 1'b1;

  led_pwm_ctrl dut (
    .clk_sys_i    (clk),
    .rst_n_i      (rst_n),
    .mm_s_addr_i  (addr),
    .mm_s_wdata_i (wdata),
    .mm_s_rdata_o (rdata),
    .mm_s_we_i    (we),
    .led_o        (led)
  );

  always #5 clk = ~clk;

  // Model: registers plus "cycles since clear" and "ticks since channel clear".
  int          m_en;
  int          m_presc;
  int          m_cyc;
  logic [14:0] m_ch [NL];
  int          m_k [NL];
  logic [7:0]  m_led;

  function automatic int tri_wave(input int s, input int d);
    int p;
    if (d == 0) return 0;
    p = s % (2 * d);
    return (p <= d) ? p : 2 * d - p;
  endfunction

  function automatic int duty_eff(input int i);
    int d, r, s;
    d = int'(m_ch[i][7:0]);
    r = int'(m_ch[i][11:8]) + 1;
    s = m_k[i] / r;
    case (m_ch[i][13:12])
      2'b01:   return (s % 2 == 0) ? d : 0;
      2'b10:   return tri_wave(s, d);
      default: return d;
    endcase
  endfunction

  function automatic logic [15:0] exp_read(input logic [7:0] a8);
    int a;
    a = int'(a8) - 'h10;
    if (a == 0) return 16'(m_en);
    if (a == 1) return 16'(m_presc);
    if (a == 2) return {8'h00, m_led};
    if (a >= 3 && a < 3 + NL) return {1'b0, m_ch[a-3]};
    return 16'h0000;
  endfunction

  task automatic model_step();
    int a, pwm;
    bit restart, tick;
    logic [NL-1:0] nled;
    bit done [NL];
    a = int'(addr) - 'h10;
    restart = we && a == 0 && wdata[1];
    pwm = m_cyc % 256;
    tick = (m_en != 0) && ((m_cyc % (m_presc + 1)) == m_presc);
    for (int i = 0; i < NL; i++) begin
      nled[i] = (m_en != 0) && m_ch[i][14] && (pwm < duty_eff(i));
      done[i] = (m_en != 0) && m_ch[i][14] && m_ch[i][13:12] == 2'b11 && tick &&
                m_k[i] == (int'(m_ch[i][11:8]) + 1) * 16 - 1 && !restart && !(we && a == 3 + i);
    end
    for (int i = 0; i < NL; i++) begin
      if (m_en == 0 || restart || (we && a == 3 + i)) m_k[i] = 0;
      else if (tick) m_k[i]++;
    end
    if (m_en == 0 || restart) m_cyc = 0;
    else m_cyc++;
    for (int i = 0; i < NL; i++) if (done[i]) m_ch[i][14] = 1'b0;
    if (we) begin
      if (a == 0) m_en = int'(wdata[0]);
      else if (a == 1) m_presc = int'(wdata);
      else if (a >= 3 && a < 3 + NL) m_ch[a-3] = wdata[14:0];
    end
    m_led = nled;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en = 0; m_presc = 0; m_cyc = 0; m_led = '0;
      for (int i = 0; i < NL; i++) begin m_ch[i] = '0; m_k[i] = 0; end
    end else begin
      model_step();
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Every-cycle comparison of LED drive and readback against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("led_o", {8'h00, led}, {8'h00, m_led ^ 8'hFF});
      check("rdata", rdata, exp_read(addr));
    end
  end

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [15:0] exp);
    addr = a; we = 1'b0; #1;
    check(name, rdata, exp);
  endtask

  task automatic set_presc(input logic [15:0] p);
    wr(8'h10, 16'h0000);
    wr(8'h11, p);
    wr(8'h10, 16'h0001);
  endtask

  int cnt, cnt_a, cnt_b, cnt_c;
  int exp_seq [10] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
  logic [7:0] odd_addr [5] = '{8'h12, 8'h1B, 8'h0F, 8'hFF, 8'h1C};

  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_led", {8'h00, led}, 16'h00FF);
    for (int a = 'h10; a <= 'h1A; a++) rd_chk("reset_reg", 8'(a), 16'h0000);
    rd_chk("reset_status", 8'h12, 16'h0000);

    // Static: full duty is on 255 of every 256 cycles, zero duty never.
    wr(8'h10, 16'h0001);
    wr(8'h13, 16'h40FF);
    idle(1);
    cnt = 0;
    repeat (256) begin @(negedge clk); if (!led[0]) cnt++; end
    @(posedge clk); #1;
    check("static_ff_on", 16'(cnt), 16'd255);
    wr(8'h13, 16'h4000);
    idle(2);
    cnt = 0;
    repeat (256) begin @(negedge clk); if (!led[0]) cnt++; end
    @(posedge clk); #1;
    check("static_00_on", 16'(cnt), 16'd0);
    rd_chk("ch0_read", 8'h13, 16'h4000);

    // Blink: PRESC=9, rate 3 -> 40-cycle phases.
    set_presc(16'd9);
    wr(8'h14, 16'h5380);
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int j = 0; j < 120; j++) begin
      @(negedge clk);
      if (j >= 5 && j < 35 && !led[1]) cnt_a++;
      if (j >= 45 && j < 75 && !led[1]) cnt_b++;
      if (j >= 85 && j < 115 && !led[1]) cnt_c++;
    end
    @(posedge clk); #1;
    check("blink_on1", 16'(cnt_a), 16'd30);
    check("blink_off", 16'(cnt_b), 16'd0);
    check("blink_on2", 16'(cnt_c), 16'd30);
    wr(8'h14, 16'h0000);

    // Pulse: rate 0 at PRESC=0 is 16 cycles of light, then enable self-clears.
    set_presc(16'd0);
    wr(8'h15, 16'h70FF);
    cnt = 0;
    repeat (40) begin @(negedge clk); if (!led[2]) cnt++; end
    @(posedge clk); #1;
    check("pulse_len", 16'(cnt), 16'd16);
    rd_chk("pulse_ch2", 8'h15, 16'h30FF);
    check("pulse_off", {15'h0, led[2]}, 16'h0001);
    wr(8'h15, 16'h70FF);
    idle(15);
    wr(8'h15, 16'h70AA);
    rd_chk("pulse_race", 8'h15, 16'h70AA);
    idle(20);

    // Breathe: model triangle pinned, then the DUT follows the model every cycle.
    for (int s = 0; s < 10; s++) check("tri_seq", 16'(tri_wave(s, 4)), 16'(exp_seq[s]));
    wr(8'h16, 16'h6004);
    idle(300);

    // Corners: RO and unmapped writes, disable mid-blink, reset mid-pulse.
    wr(8'h12, 16'hFFFF);
    wr(8'h1B, 16'hFFFF);
    rd_chk("unmapped_rd", 8'h1B, 16'h0000);
    wr(8'h14, 16'h5180);
    idle(20);
    wr(8'h10, 16'h0000);
    idle(1);
    check("disable_off", {8'h00, led}, 16'h00FF);
    wr(8'h10, 16'h0001);
    wr(8'h15, 16'h70FF);
    idle(5);
    rst_n = 1'b0;
    #1;
    check("async_rst_led", {8'h00, led}, 16'h00FF);
    rd_chk("async_rst_ch2", 8'h15, 16'h0000);
    rd_chk("async_rst_ctrl", 8'h10, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 10) begin
        wr(8'h10, {14'h0, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) != 0)});
      end else if (r < 12) begin
        set_presc(16'($urandom_range(0, 5)));
      end else if (r < 25) begin
        wr(8'h13 + 8'($urandom_range(0, NL - 1)), 16'($urandom));
      end else if (r < 28) begin
        wr(odd_addr[$urandom_range(0, 4)], 16'($urandom));
      end else begin
        addr = 8'($urandom_range('h0E, 'h1C));
        we = 1'b0;
        idle(1);
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
